midi_uart_rx: RTL and testbench
===============================

MIDI_UART_RX -- requirements
Module: midi_uart_rx

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 31_250, MIDI serial bit rate.
REQ-003 SHALL have port clock_50_000_000, input, 1, the single clock; every register is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset, sampled only on a rising clock edge.
REQ-005 SHALL have port rx, input, 1, asynchronous MIDI serial line; idles high.
REQ-006 SHALL have port data_out, output, CONFIG::BYTE_WIDTH (8), last correctly framed byte.
REQ-007 SHALL have port data_out_ready, output, 1, one-cycle pulse marking a new data_out; feeds the decoder's data_in_ready.
REQ-008 SHALL have port framing_error, output, 1, one-cycle pulse when a stop bit samples low.

Function
REQ-009 SHALL pass rx through a two-flop synchronizer (rx_sync); all decisions use rx_sync only.
REQ-010 SHALL use CLKS_PER_BIT = CLOCK_HZ/BAUD_RATE (1600 at defaults) and HALF_BIT = CLKS_PER_BIT/2 (800).
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH with a bit-timing counter and a 3-bit bit index.
REQ-012 IDLE: rx_sync==0 -> START with the counter cleared; otherwise stay.
REQ-013 START: at counter==HALF_BIT-1, rx_sync==0 -> DATA with the counter and bit index cleared; rx_sync==1 -> IDLE as a glitch, with no output pulse.
REQ-014 DATA: at counter==CLKS_PER_BIT-1, sample the bit into the shift register LSB-first and clear the counter; after bit index 7 -> STOP.
REQ-015 STOP: at counter==CLKS_PER_BIT-1, a high sample loads data_out from the shift register, pulses data_out_ready for exactly one cycle, and -> IDLE.
REQ-016 STOP: a low sample pulses framing_error for one cycle, leaves data_out unchanged, and -> WAIT_HIGH.
REQ-017 WAIT_HIGH: stay until rx_sync==1, then -> IDLE; a break (line held low) SHALL never produce data_out_ready.
REQ-018 data_out_ready and framing_error SHALL never be asserted in the same cycle.
REQ-019 Latency: data_out_ready SHALL rise 9.5 bit times (15,200 cycles) +2..+4 cycles after the rx start-bit falling edge.
REQ-020 Back-to-back bytes with zero idle gap SHALL all be received, because IDLE re-arms on the cycle after the stop-bit sample.
REQ-021 data_out SHALL hold its value between pulses; there is no downstream backpressure.

Reset
REQ-022 On reset: state=IDLE, counter=0, bit index=0, shift register=0, data_out=0, data_out_ready=0, framing_error=0, synchronizer flops=1.
REQ-023 Reset asserted mid-byte SHALL abandon the byte with no pulse; reception resumes at the next falling edge after reset deasserts.

Configuration
REQ-024 With macro MIDI_RX_MAJORITY_EN defined, each data bit and stop bit SHALL be the 2-of-3 majority of samples taken at counter values CLKS_PER_BIT-201, CLKS_PER_BIT-101 and CLKS_PER_BIT-1; the decision cycle is unchanged.
REQ-025 Without MIDI_RX_MAJORITY_EN, each bit SHALL be a single sample at counter==CLKS_PER_BIT-1; the start bit is always single-sampled.

Structure
REQ-026 MIDI::BAUD_RATE (31_250) and the state_t enum SHALL live in the shared MIDI package; BYTE_WIDTH SHALL come from CONFIG.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff (parameterised reset value), reusable by other input pins.

Verification
REQ-028 Send 0x90 with ideal timing -> exactly one data_out_ready pulse with data_out=0x90, 15,202-15,204 cycles after the falling edge.
REQ-029 Send a 400-cycle low glitch on an idle line -> no data_out_ready, no framing_error, state back in IDLE.
REQ-030 Send 0x3C with the stop bit driven low -> one framing_error pulse, data_out unchanged; hold low 10 bit times, release, then send 0xB0 -> data_out=0xB0.
REQ-031 Send 0x90, 0x3C, 0x64 back-to-back -> three pulses 16,000 cycles apart with matching data_out values.
REQ-032 Assert reset at bit 4 of 0x45 -> all outputs 0 and no pulse; then send 0x80 -> data_out=0x80.
REQ-033 With MIDI_RX_MAJORITY_EN, invert rx for 20 cycles around the count-101 sample of bit 2 of 0x55 -> data_out=0x55; without the macro, the same 20-cycle invert around the final sample -> data_out=0x51.

Source files
------------

// File: rtl/midi_uart_rx_pkg.sv
// Shared definitions for the MIDI receiver: CONFIG holds datapath widths,
// MIDI holds protocol constants, receiver FSM states and the bit-vote helper.
package CONFIG;
    localparam int BYTE_WIDTH = 8;
endpackage

package MIDI;
    localparam int BAUD_RATE = 31_250;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/midi_uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input pin; the reset value is a
// parameter so idle-high lines do not look active while reset is released.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    // NOTE: non-blocking assignments keep this a true two-stage pipeline; q takes meta's old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/midi_uart_rx.sv
// MIDI (31.25 kbaud, 8N1) UART receiver with framing-error detection.
// Define MIDI_RX_MAJORITY_EN to vote each data/stop bit from three samples.
module midi_uart_rx #(
    parameter int CLOCK_HZ  = 50_000_000,
    parameter int BAUD_RATE = MIDI::BAUD_RATE
) (
    input  logic                          clock_50_000_000,
    input  logic                          reset,
    input  logic                          rx,
    output logic [CONFIG::BYTE_WIDTH-1:0] data_out,
    output logic                          data_out_ready,
    output logic                          framing_error
);
    import MIDI::*;

    localparam int BW           = CONFIG::BYTE_WIDTH;
    localparam int CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(HALF_BIT - 1);
    localparam logic [2:0]    LAST_BIT = 3'(BW - 1);

    logic          rx_sync;
    logic          bit_val;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [BW-1:0] shift;

    // Idle line is high, so the synchronizer must reset high to avoid a false start bit.
    sync_2ff #(.RESET_VALUE(1'b1)) u_rx_sync (
        .clk   (clock_50_000_000),
        .reset (reset),
        .d     (rx),
        .q     (rx_sync)
    );

`ifdef MIDI_RX_MAJORITY_EN
    localparam logic [CW-1:0] EARLY_CNT = CW'(CLKS_PER_BIT - 201);
    localparam logic [CW-1:0] MID_CNT   = CW'(CLKS_PER_BIT - 101);

    logic early_s;
    logic mid_s;

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            early_s <= 1'b1;
            mid_s   <= 1'b1;
        end else begin
            if (cnt == EARLY_CNT) early_s <= rx_sync;
            if (cnt == MID_CNT)   mid_s   <= rx_sync;
        end
    end

    assign bit_val = majority3(early_s, mid_s, rx_sync);
`else
    assign bit_val = rx_sync;
`endif

    always_ff @(posedge clock_50_000_000) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            data_out       <= '0;
            data_out_ready <= 1'b0;
            framing_error  <= 1'b0;
        end else begin
            // Both status outputs are single-cycle pulses unless a branch below raises one.
            data_out_ready <= 1'b0;
            framing_error  <= 1'b0;
            cnt            <= cnt + CW'(1);

            case (state)
                IDLE: begin
                    if (!rx_sync) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt == LAST_CNT) begin
                        cnt     <= '0;
                        shift   <= {bit_val, shift[BW-1:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) state <= STOP;
                    end
                end
                STOP: begin
                    if (cnt == LAST_CNT) begin
                        cnt <= '0;
                        if (bit_val) begin
                            data_out       <= shift;
                            data_out_ready <= 1'b1;
                            state          <= IDLE;
                        end else begin
                            framing_error <= 1'b1;
                            state         <= WAIT_HIGH;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) parks here until it returns high.
                    if (rx_sync) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_midi_uart_rx.sv
// Self-checking bench for midi_uart_rx: directed and random frames scored
// against a queue-based model of the expected receive events.
`timescale 1ns/1ps
module tb_midi_uart_rx;
    // Scaled clock keeps runtime short while leaving room for the 3-sample vote window.
    localparam int CLOCK_HZ = 14_000_000;
    localparam int BAUD     = 31_250;
    localparam int CPB      = CLOCK_HZ / BAUD;
    localparam int HALF     = CPB / 2;
    localparam int LAT_LO   = (19 * CPB) / 2 + 2;
    localparam int LAT_HI   = (19 * CPB) / 2 + 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] data_out;
    logic       data_out_ready;
    logic       framing_error;

    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_data = 8'h00;
    logic [7:0] b45   = 8'h45;
    logic [7:0] rnd_b;
    logic       rnd_stop;

    typedef struct {logic fe; logic [7:0] data; int t;} exp_t;
    typedef struct {logic fe; logic rdy; logic [7:0] data; int t;} obs_t;
    exp_t exp_q[$];
    obs_t obs_q[$];

    midi_uart_rx #(.CLOCK_HZ(CLOCK_HZ), .BAUD_RATE(BAUD)) dut (
        .clock_50_000_000 (clk),
        .reset            (reset),
        .rx               (rx),
        .data_out         (data_out),
        .data_out_ready   (data_out_ready),
        .framing_error    (framing_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_out_ready || framing_error)
            obs_q.push_back('{framing_error, data_out_ready, data_out, cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // One 8N1 frame; optionally inverts data bit gbit for glen cycles starting goff into it.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic [7:0] want,
                              input int gbit, input int goff, input int glen);
        exp_q.push_back('{!stop, want, cyc});
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == gbit) begin
                hold(b[i], goff);
                hold(!b[i], glen);
                hold(b[i], CPB - goff - glen);
            end else begin
                hold(b[i], CPB);
            end
        end
        hold(stop, CPB);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b1, b, -1, 0, 0);
    endtask

    // Match observed pulses against expected events, in order.
    task automatic drain();
        exp_t e;
        obs_t o;
        int   lat;
        repeat (8) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                check("event_missing", 32'd0, 32'd1);
                continue;
            end
            o = obs_q.pop_front();
            check("pulse_is_fe", o.fe, e.fe);
            check("pulse_exclusive", o.fe & o.rdy, 0);
            if (e.fe) begin
                check("data_held_on_fe", o.data, model_data);
            end else begin
                check("data_out", o.data, e.data);
                model_data = e.data;
            end
            lat = o.t - e.t;
            check("latency", lat, (lat < LAT_LO) ? LAT_LO : (lat > LAT_HI) ? LAT_HI : lat);
        end
        check("extra_events", obs_q.size(), 0);
        obs_q.delete();
        check("data_out_hold", data_out, model_data);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_ready", data_out_ready, 0);
        check("rst_fe", framing_error, 0);
        reset = 1'b0;
        hold(1'b1, 20);

        send(8'h90);
        drain();

        // Short low glitch must be rejected; the following byte proves the FSM is idle again.
        hold(1'b0, 100);
        hold(1'b1, 2 * CPB);
        drain();
        send(8'hA5);
        drain();

        // Framing error, then a 10-bit break, then recovery.
        send_frame(8'h3C, 1'b0, 8'h3C, -1, 0, 0);
        hold(1'b0, 10 * CPB);
        hold(1'b1, 64);
        send(8'hB0);
        drain();

        send(8'h90);
        send(8'h3C);
        send(8'h64);
        drain();

        // Reset in the middle of bit 4 of 0x45.
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(b45[i], CPB);
        hold(b45[4], HALF);
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_data_out", data_out, 0);
        check("midrst_ready", data_out_ready, 0);
        check("midrst_fe", framing_error, 0);
        reset = 1'b0;
        model_data = 8'h00;
        hold(1'b1, 2 * CPB);
        drain();
        send(8'h80);
        drain();

        // The final bit decision sees rx about HALF+1 cycles into the bit (two-flop delay);
        // the vote's middle sample is 100 cycles earlier. Each window straddles its target sample.
`ifdef MIDI_RX_MAJORITY_EN
        send_frame(8'h55, 1'b1, 8'h55, 2, HALF - 109, 20);
`else
        send_frame(8'h55, 1'b1, 8'h51, 2, HALF - 9, 20);
`endif
        drain();

        for (int k = 0; k < 4; k++) begin
            rnd_b    = 8'($urandom);
            rnd_stop = ($urandom_range(0, 3) != 0);
            send_frame(rnd_b, rnd_stop, rnd_b, -1, 0, 0);
            hold(1'b1, $urandom_range(8, CPB));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
